// File: rtl/seq_hit_display.sv
// seq_hit_display: counts sequence-detector hits in a 2-digit BCD counter and
// multiplexes ones / tens / detector-state digits onto a common-anode
// 4-digit 7-segment display. Emits a one-cycle hit strobe per counted detection.
// Optional build macro: HIT_COUNT_SAT_EN (saturate at 99, sticky flag, "F" on digit 3).
module seq_hit_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic       clk_pulse,
    input  logic       clear,
    input  logic       det_out,
    input  logic [2:0] det_state,
    input  logic       hold,
    output logic       hit,
    output logic [7:0] count_bcd,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic {S_RUN, S_FROZEN} state_t;

    state_t                  r_state;
    logic                    r_hit;
    logic [7:0]              r_count;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [3:0]              r_an;
    logic [6:0]              r_seg;

    logic [7:0]              w_next;
    logic                    w_count_en;
    logic [1:0]              w_sel;
    logic [6:0]              w_digit3;

    // Active-low glyphs for 0-9; anything else is blanked.
    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        case (v)
            4'd0:    f_glyph = 7'b1000000;
            4'd1:    f_glyph = 7'b1111001;
            4'd2:    f_glyph = 7'b0100100;
            4'd3:    f_glyph = 7'b0110000;
            4'd4:    f_glyph = 7'b0011001;
            4'd5:    f_glyph = 7'b0010010;
            4'd6:    f_glyph = 7'b0000010;
            4'd7:    f_glyph = 7'b1111000;
            4'd8:    f_glyph = 7'b0000000;
            4'd9:    f_glyph = 7'b0010000;
            default: f_glyph = SEG_BLANK;
        endcase
    endfunction

    // BCD increment: ones roll 9->0 carrying into tens, tens roll 9->0 (99 -> 00).
    always_comb begin
        w_next = r_count;
        if (r_count[3:0] == 4'd9) begin
            w_next[3:0] = 4'd0;
            w_next[7:4] = (r_count[7:4] == 4'd9) ? 4'd0 : r_count[7:4] + 4'd1;
        end else begin
            w_next[3:0] = r_count[3:0] + 4'd1;
        end
    end

`ifdef HIT_COUNT_SAT_EN
    logic r_sat;

    // Once the count sits at 99 it no longer advances and no hit is raised.
    assign w_count_en = det_out && (r_count != 8'h99);
    assign w_digit3   = r_sat ? SEG_F : SEG_BLANK;

    // Sticky saturation flag, set on the edge the count becomes 99.
    always_ff @(posedge clk_pulse or posedge clear) begin
        if (clear)
            r_sat <= 1'b0;
        else if (!hold && w_count_en && (w_next == 8'h99))
            r_sat <= 1'b1;
    end
`else
    assign w_count_en = det_out;
    assign w_digit3   = SEG_BLANK;
`endif

    // Counter FSM: hold freezes counting; leaving FROZEN counts on the same edge.
    always_ff @(posedge clk_pulse or posedge clear) begin
        if (clear) begin
            r_state <= S_RUN;
            r_hit   <= 1'b0;
            r_count <= 8'h00;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (hold) begin
                        r_state <= S_FROZEN;
                        r_hit   <= 1'b0;
                    end else begin
                        r_hit <= w_count_en;
                        if (w_count_en)
                            r_count <= w_next;
                    end
                end
                S_FROZEN: begin
                    if (hold) begin
                        r_hit <= 1'b0;
                    end else begin
                        r_state <= S_RUN;
                        r_hit   <= w_count_en;
                        if (w_count_en)
                            r_count <= w_next;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_hit   <= 1'b0;
                end
            endcase
        end
    end

    assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

    // Free-running refresh counter and registered digit mux (one cycle behind sel).
    always_ff @(posedge clk_pulse or posedge clear) begin
        if (clear) begin
            r_refresh <= '0;
            r_an      <= 4'b1110;
            r_seg     <= SEG_ZERO;
        end else begin
            r_refresh <= r_refresh + REFRESH_BITS'(1);
            case (w_sel)
                2'd0: begin
                    r_an  <= 4'b1110;
                    r_seg <= f_glyph(r_count[3:0]);
                end
                2'd1: begin
                    r_an  <= 4'b1101;
                    r_seg <= f_glyph(r_count[7:4]);
                end
                2'd2: begin
                    r_an  <= 4'b1011;
                    r_seg <= f_glyph({1'b0, det_state});
                end
                default: begin
                    r_an  <= 4'b0111;
                    r_seg <= w_digit3;
                end
            endcase
        end
    end

    assign hit       = r_hit;
    assign count_bcd = r_count;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule
